// File: rtl/ahb_bridge_pkg.sv
// Shared constants and helpers for the AHB-to-APB bridge arbiter.
package ahb_bridge_pkg;

    // AHB htrans encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Arbiter FSM state encodings (also exported on arb_state)
    localparam logic [1:0] ARB_ST_PARK = 2'd0;
    localparam logic [1:0] ARB_ST_OWN  = 2'd1;
    localparam logic [1:0] ARB_ST_LOCK = 2'd2;

    // Index of the set bit of a one-hot vector of up to 8 bits.
    // The input is expected to be one-hot; if it is not, the OR of the
    // indices of all set bits is returned.
    function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = idx | (oh[i] ? i[2:0] : 3'd0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ahb_bridge_arbiter_rr_picker.sv
// Combinational round-robin winner search for the bridge arbiter.
// Searches the other requesters starting just after rr_ptr (wrapping) and
// falls back to the current owner, so the owner is always considered last.
module ahb_bridge_arbiter_rr_picker
    import ahb_bridge_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MST_W       = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [MST_W-1:0]       rr_ptr,
    input  logic [MST_W-1:0]       owner,
    output logic [MST_W-1:0]       winner,
    output logic                   any_other
);

    localparam logic [MST_W:0]       NM_W   = (MST_W + 1)'(NUM_MASTERS);
    localparam logic [NUM_MASTERS-1:0] ONE_N = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

    logic [NUM_MASTERS-1:0]   others_s;
    logic [NUM_MASTERS-1:0]   rot_s;
    logic [2*NUM_MASTERS-1:0] dbl_s;
    logic [MST_W:0]           start_raw_s;
    logic [MST_W:0]           start_s;
    logic [MST_W:0]           sum_s;
    logic [MST_W:0]           wrap_s;
    logic [MST_W-1:0]         pos_s;
    logic                     unused_s;

    // Rotate the non-owner requests to start at rr_ptr+1, take the lowest set
    // bit, then map that position back to a master index.
    always_comb begin
        others_s    = req & ~(ONE_N << owner);
        start_raw_s = {1'b0, rr_ptr} + {{MST_W{1'b0}}, 1'b1};
        start_s     = (start_raw_s >= NM_W) ? (start_raw_s - NM_W) : start_raw_s;
        dbl_s       = {others_s, others_s} >> start_s;
        rot_s       = dbl_s[NUM_MASTERS-1:0];
        pos_s       = {MST_W{1'b0}};
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            pos_s = rot_s[i] ? i[MST_W-1:0] : pos_s;
        end
        sum_s     = start_s + {1'b0, pos_s};
        wrap_s    = (sum_s >= NM_W) ? (sum_s - NM_W) : sum_s;
        any_other = |others_s;
        winner    = any_other ? wrap_s[MST_W-1:0] : owner;
    end

    // Upper halves of the rotation and carry bit are structurally unused.
    assign unused_s = ^{dbl_s[2*NUM_MASTERS-1:NUM_MASTERS], wrap_s[MST_W]};

endmodule

// File: rtl/ahb_bridge_arbiter.sv
// Round-robin AHB arbiter sharing the single AHB-to-APB bridge.
// Produces a registered one-hot hgrant plus the registered address-phase
// owner (hmaster) and lock flag (hmastlock). Locked transfers keep the bus,
// SEQ bursts keep the bus up to a hold limit while others are waiting.
module ahb_bridge_arbiter
    import ahb_bridge_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int MST_W          = 2,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_HOLD       = 16
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MST_W-1:0]       hmaster,
    output logic                   hmastlock,
    output logic [1:0]             arb_state
);

    localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HC_W-1:0]        HOLD_LAST = HC_W'(MAX_HOLD - 1);
    localparam logic [HC_W-1:0]        HC_ZERO   = {HC_W{1'b0}};
    localparam logic [HC_W-1:0]        HC_ONE    = HC_W'(1);
    localparam logic [NUM_MASTERS-1:0] ONE_N     = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = ONE_N << DEFAULT_MASTER;
    localparam logic [MST_W-1:0]       DEF_IDX   = MST_W'(DEFAULT_MASTER);

    logic [1:0]             state_q,     state_d;
    logic [NUM_MASTERS-1:0] grant_q,     grant_d;
    logic [MST_W-1:0]       hmaster_q,   hmaster_d;
    logic                   hmastlock_q, hmastlock_d;
    logic [MST_W-1:0]       rr_ptr_q,    rr_ptr_d;
    logic [HC_W-1:0]        hold_cnt_q,  hold_cnt_d;

    logic [MST_W-1:0]       owner_s;
    logic [MST_W-1:0]       winner_s;
    logic [NUM_MASTERS-1:0] winner_oh_s;
    logic                   any_other_s;
    logic                   any_req_s;
    logic                   own_req_s;
    logic                   own_lock_s;
    logic                   rearb_s;

    assign owner_s = MST_W'(onehot2idx(8'(grant_q)));

    ahb_bridge_arbiter_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .MST_W       (MST_W)
    ) u_picker (
        .req       (hbusreq),
        .rr_ptr    (rr_ptr_q),
        .owner     (owner_s),
        .winner    (winner_s),
        .any_other (any_other_s)
    );

    // Decode the owner's request/lock and the three rearbitration triggers.
    always_comb begin
        winner_oh_s = ONE_N << winner_s;
        any_req_s   = |hbusreq;
        own_req_s   = hbusreq[owner_s];
        own_lock_s  = hlock[owner_s] & own_req_s;
        rearb_s     = ~own_req_s
                    | ((htrans != HTRANS_SEQ) & any_other_s)
                    | ((hold_cnt_q == HOLD_LAST) & any_other_s);
    end

    // Next-state logic; nothing moves on a cycle with hready low.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        rr_ptr_d    = rr_ptr_q;
        hold_cnt_d  = hold_cnt_q;
        if (hready) begin
            // Address phase follows the grant one ready cycle later.
            hmaster_d   = owner_s;
            hmastlock_d = hlock[owner_s];
            case (state_q)
                ARB_ST_PARK: begin
                    if (any_req_s) begin
                        state_d    = ARB_ST_OWN;
                        grant_d    = winner_oh_s;
                        hold_cnt_d = HC_ZERO;
                        if (winner_s != owner_s) begin
                            rr_ptr_d = winner_s;
                        end else begin
                            rr_ptr_d = rr_ptr_q;
                        end
                    end else begin
                        grant_d = DEF_GRANT;
                    end
                end
                ARB_ST_OWN, ARB_ST_LOCK: begin
                    if ((state_q == ARB_ST_LOCK) && hlock[owner_s]) begin
                        // Locked sequence: grant is untouchable.
                        hold_cnt_d = HC_ZERO;
                    end else if (own_lock_s) begin
                        state_d    = ARB_ST_LOCK;
                        hold_cnt_d = HC_ZERO;
                    end else if (!any_req_s) begin
                        state_d    = ARB_ST_PARK;
                        grant_d    = DEF_GRANT;
                        hold_cnt_d = HC_ZERO;
                    end else if (rearb_s) begin
                        // A trigger with requests pending always has a
                        // different winner, so this is a real handover.
                        state_d    = ARB_ST_OWN;
                        grant_d    = winner_oh_s;
                        rr_ptr_d   = winner_s;
                        hold_cnt_d = HC_ZERO;
                    end else begin
                        state_d = ARB_ST_OWN;
                        if (any_other_s && (hold_cnt_q != HOLD_LAST)) begin
                            hold_cnt_d = hold_cnt_q + HC_ONE;
                        end else begin
                            hold_cnt_d = hold_cnt_q;
                        end
                    end
                end
                default: begin
                    state_d    = ARB_ST_PARK;
                    grant_d    = DEF_GRANT;
                    rr_ptr_d   = DEF_IDX;
                    hold_cnt_d = HC_ZERO;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with asynchronous reset to the parked owner.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q     <= ARB_ST_PARK;
            grant_q     <= DEF_GRANT;
            hmaster_q   <= DEF_IDX;
            hmastlock_q <= 1'b0;
            rr_ptr_q    <= DEF_IDX;
            hold_cnt_q  <= HC_ZERO;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign hgrant    = grant_q;
    assign hmaster   = hmaster_q;
    assign hmastlock = hmastlock_q;
    assign arb_state = state_q;

endmodule
